// File: rtl/ascii_region_copier.sv
`default_nettype none
// ==== ascii_region_copier : copies cells [lo..hi] of the ASCII master RAM into the VGA back buffer ====
// ==== after each buffer switch; ASCII_COPY_OVERRUN_EN adds a sticky overrun flag.  Rev 1.0        ====
module ascii_region_copier #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 13,
  parameter int CELLS       = 4800,
  parameter int RD_LAT      = 1,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] region_lo,
  input  logic [ADDR_W-1:0] region_hi,
  input  logic              buffer_switched,
  output logic [ADDR_W-1:0] master_read_address,
  input  logic [DATA_W-1:0] master_data_out,
  output logic [ADDR_W-1:0] vga_write_address,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_write_strobe,
  output logic              vga_write_done,
  output logic              busy,
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [3:0]        RD_END    = 4'(RD_LAT - 1);
  localparam logic [3:0]        HOLD_END  = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_DONE,
    S_WAIT_SWITCH,
    S_COPY_START,
    S_READ,
    S_HOLD
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] hi_clamp;
  logic [3:0]        cnt, cnt_d;
  logic [DATA_W-1:0] data_d;
  logic              strobe_d, done_d, busy_d;

  assign hi_clamp            = (region_hi > LAST_CELL) ? LAST_CELL : region_hi;
  assign master_read_address = addr;
  assign vga_write_address   = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_DONE;
      addr             <= '0;
      lo_q             <= '0;
      hi_q             <= '0;
      cnt              <= '0;
      vga_data         <= '0;
      vga_write_strobe <= 1'b0;
      vga_write_done   <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_d;
      addr             <= addr_d;
      lo_q             <= lo_d;
      hi_q             <= hi_d;
      cnt              <= cnt_d;
      vga_data         <= data_d;
      vga_write_strobe <= strobe_d;
      vga_write_done   <= done_d;
      busy             <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt;
    data_d   = vga_data;
    strobe_d = vga_write_strobe;
    done_d   = vga_write_done;
    busy_d   = busy;
    case (state)
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_WAIT_SWITCH;
      end
      S_WAIT_SWITCH: begin
        if (buffer_switched) begin
          lo_d = region_lo;
          hi_d = hi_clamp;
          // An empty region still completes a frame, so done is left asserted.
          if (region_lo > hi_clamp) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COPY_START;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      S_COPY_START: begin
        addr_d  = lo_q;
        cnt_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        if (cnt == RD_END) begin
          cnt_d    = '0;
          data_d   = master_data_out;
          strobe_d = 1'b1;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_END) begin
          cnt_d    = '0;
          strobe_d = 1'b0;
          // Termination is tested before the increment, so addr never wraps.
          if (addr == hi_q) begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            addr_d  = addr + ADDR_W'(1);
            state_d = S_READ;
          end
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      default: state_d = S_DONE;
    endcase
  end

`ifdef ASCII_COPY_OVERRUN_EN
  logic overrun_q;

  // A switch seen outside WAIT_SWITCH means a partially copied frame was displayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (buffer_switched && (state != S_WAIT_SWITCH)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascii_region_copier.sv
`default_nettype none
// tb_ascii_region_copier: random RAM contents and regions checked against a per-cell window model
// for a default-parameter instance and a RD_LAT=3 / HOLD_CYCLES=2 / CELLS=64 instance.
module tb_ascii_region_copier;
  localparam int DW      = 32;
  localparam int AW      = 13;
  localparam int CELLS_A = 4800;
  localparam int RD_A    = 1;
  localparam int HOLD_A  = 8;
  localparam int CELLS_B = 64;
  localparam int RD_B    = 3;
  localparam int HOLD_B  = 2;
`ifdef ASCII_COPY_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
    int          start;
    int          len;
    bit          stable;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] lo_a, hi_a, lo_b, hi_b;
  logic          sw_a, sw_b;
  logic [AW-1:0] rd_a, rd_b, wa_a, wa_b;
  logic [DW-1:0] q_a, q_b, vd_a, vd_b, p1_b, p2_b;
  logic          str_a, str_b, done_a, done_b, busy_a, busy_b, ovr_a, ovr_b;

  logic [DW-1:0] mem [0:CELLS_A-1];

  ascii_region_copier #(.DATA_W(DW), .ADDR_W(AW), .CELLS(CELLS_A), .RD_LAT(RD_A), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .rst(rst), .region_lo(lo_a), .region_hi(hi_a), .buffer_switched(sw_a),
    .master_read_address(rd_a), .master_data_out(q_a), .vga_write_address(wa_a), .vga_data(vd_a),
    .vga_write_strobe(str_a), .vga_write_done(done_a), .busy(busy_a), .overrun(ovr_a));

  ascii_region_copier #(.DATA_W(DW), .ADDR_W(AW), .CELLS(CELLS_B), .RD_LAT(RD_B), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .rst(rst), .region_lo(lo_b), .region_hi(hi_b), .buffer_switched(sw_b),
    .master_read_address(rd_b), .master_data_out(q_b), .vga_write_address(wa_b), .vga_data(vd_b),
    .vga_write_strobe(str_b), .vga_write_done(done_b), .busy(busy_b), .overrun(ovr_b));

  // RAM models: q is valid RD_LAT cycles after the address first appears.
  always_comb q_a = (int'(rd_a) < CELLS_A) ? mem[rd_a] : '0;
  always @(posedge clk) begin
    p1_b <= mem[rd_b];
    p2_b <= p1_b;
  end
  always_comb q_b = p2_b;

  wire [1:0]         strb  = {str_b, str_a};
  wire [1:0]         donev = {done_b, done_a};
  wire [1:0]         busyv = {busy_b, busy_a};
  wire [1:0][AW-1:0] waddr = {wa_b, wa_a};
  wire [1:0][DW-1:0] vdat  = {vd_b, vd_a};

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  win_t win_a[$];
  win_t win_b[$];
  win_t cur[2];
  logic [1:0] str_prev = '0;
  logic [1:0] done_prev = '0;
  int done_rise[2] = '{-1, -1};
  int done_low[2]  = '{0, 0};
  int busy_cnt[2]  = '{0, 0};
  int busy_bad[2]  = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (strb[d]) begin
        if (!str_prev[d]) begin
          cur[d].addr = int'(waddr[d]); cur[d].data = vdat[d];
          cur[d].start = cyc; cur[d].len = 1; cur[d].stable = 1'b1;
        end else begin
          cur[d].len++;
          if (int'(waddr[d]) != cur[d].addr || vdat[d] !== cur[d].data) cur[d].stable = 1'b0;
        end
        if (!busyv[d] || donev[d]) busy_bad[d]++;
      end else if (str_prev[d]) begin
        if (d == 0) win_a.push_back(cur[d]); else win_b.push_back(cur[d]);
      end
      if (busyv[d]) busy_cnt[d]++;
      if (donev[d] && !done_prev[d]) done_rise[d] = cyc;
      if (!donev[d]) done_low[d]++;
      str_prev[d]  = strb[d];
      done_prev[d] = donev[d];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input int lo, input int hi, input logic sw);
    if (d == 0) begin lo_a = AW'(lo); hi_a = AW'(hi); sw_a = sw; end
    else        begin lo_b = AW'(lo); hi_b = AW'(hi); sw_b = sw; end
  endtask

  task automatic wait_done(input int d, input int budget);
    int k = 0;
    while (donev[d] !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    chk("wait_done", donev[d], 1);
  endtask

  task automatic run_copy(input int d, input int lo, input int hi, input bit disturb);
    int cells, rd, hold, hic, n, sw_cyc, base_w, b_busy, b_bad, b_low, b_rise, k, nbad, ngap;
    win_t w[$];
    cells = (d == 0) ? CELLS_A : CELLS_B;
    rd    = (d == 0) ? RD_A : RD_B;
    hold  = (d == 0) ? HOLD_A : HOLD_B;
    hic   = (hi > cells - 1) ? cells - 1 : hi;
    n     = (lo > hic) ? 0 : hic - lo + 1;
    wait_done(d, 200);
    repeat (2) @(negedge clk);
    base_w = (d == 0) ? win_a.size() : win_b.size();
    b_busy = busy_cnt[d]; b_bad = busy_bad[d]; b_low = done_low[d]; b_rise = done_rise[d];
    drive(d, lo, hi, 1'b1);
    sw_cyc = cyc;
    @(negedge clk);
    drive(d, lo, hi, 1'b0);
    if (disturb) begin
      repeat (12) @(negedge clk);
      drive(d, $urandom_range(0, cells - 1), $urandom_range(0, cells - 1), 1'b1);
      @(negedge clk);
      drive(d, $urandom_range(0, cells - 1), $urandom_range(0, cells - 1), 1'b0);
    end
    k = 0;
    while (done_rise[d] == b_rise && k < n * (rd + hold) + 40) begin @(negedge clk); k++; end
    if (d == 0) begin for (int i = base_w; i < win_a.size(); i++) w.push_back(win_a[i]); end
    else        begin for (int i = base_w; i < win_b.size(); i++) w.push_back(win_b[i]); end
    chk("cell_count", w.size(), n);
    nbad = 0; ngap = 0;
    foreach (w[i]) begin
      if (w[i].addr != lo + i || w[i].len != hold || !w[i].stable ||
          w[i].data !== ((lo + i < CELLS_A) ? mem[lo + i] : 'x)) nbad++;
      if (i > 0 && w[i].start - w[i-1].start != rd + hold) ngap++;
    end
    chk("cell_content", nbad, 0);
    chk("cell_period", ngap, 0);
    chk("busy_cycles", busy_cnt[d] - b_busy, (n == 0) ? 0 : n * (rd + hold) + 1);
    chk("busy_overlap", busy_bad[d] - b_bad, 0);
    if (n == 0) begin
      chk("done_held", done_low[d] - b_low, 0);
    end else begin
      chk("first_latency", (w.size() > 0) ? w[0].start - sw_cyc : -1, rd + 2);
      chk("done_time", done_rise[d], sw_cyc + 3 + n * (rd + hold));
    end
  endtask

  initial begin
    for (int i = 0; i < CELLS_A; i++) mem[i] = $urandom();
    rst = 1'b0;
    drive(0, 0, 0, 1'b0);
    drive(1, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_strobe", str_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_data", vd_a, 0);
    chk("rst_waddr", wa_a, 0);
    chk("rst_raddr", rd_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_done_b", done_b, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("done_after_reset", done_a, 1);

    run_copy(0, 0, 4799, 1'b0);
    chk("overrun_idle", ovr_a, 0);
    run_copy(0, 100, 102, 1'b1);
    chk("overrun_set", ovr_a, OVR_EN);
    run_copy(0, 4790, 6000, 1'b0);
    chk("overrun_sticky", ovr_a, OVR_EN);
    run_copy(0, 50, 10, 1'b0);
    run_copy(0, 7, 7, 1'b0);

    run_copy(1, 0, 63, 1'b0);
    run_copy(1, 5, 200, 1'b0);
    for (int t = 0; t < 8; t++) run_copy(1, $urandom_range(0, 70), $urandom_range(0, 90), 1'b0);
    chk("overrun_b", ovr_b, 0);

    // Asynchronous reset in the middle of a copy.
    wait_done(0, 200);
    repeat (2) @(negedge clk);
    drive(0, 0, 20, 1'b1);
    @(negedge clk);
    drive(0, 0, 20, 1'b0);
    repeat (12) @(negedge clk);
    drive(0, 0, 20, 1'b1);
    @(negedge clk);
    drive(0, 0, 20, 1'b0);
    repeat (20) @(negedge clk);
    chk("midcopy_busy", busy_a, 1);
    chk("midcopy_overrun", ovr_a, OVR_EN);
    #2 rst = 1'b0;
    #1;
    chk("arst_strobe", str_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_data", vd_a, 0);
    chk("arst_waddr", wa_a, 0);
    chk("arst_overrun", ovr_a, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("done_after_arst", done_a, 1);
    run_copy(0, 3, 5, 1'b0);
    chk("overrun_after_arst", ovr_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
